// File: rtl/alu_md_pkg.sv
// alu_md_pkg: opcodes, FSM states and decode helpers for alu_md.
// Build macro ALU_MD_DIV_EN enables the divider datapath.
package alu_md_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_MULT  = 4'd8;
  localparam logic [3:0] OP_MULTU = 4'd9;
  localparam logic [3:0] OP_DIV   = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;
  localparam logic [3:0] OP_MFHI  = 4'd12;
  localparam logic [3:0] OP_MFLO  = 4'd13;
  localparam logic [3:0] OP_MTHI  = 4'd14;
  localparam logic [3:0] OP_MTLO  = 4'd15;

`ifdef ALU_MD_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // MULT/MULTU/DIV/DIVU occupy 8..11
  function automatic logic is_md(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_md_if.sv
// alu_md_if: issue/result handshake bundle between EX control and alu_md.
// Master side issues ops and consumes results; slave is the ALU.
interface alu_md_if
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d_out;
  logic             zero_flag;
  logic             exp_overflow;
  logic             exp_illegal;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, alu_op, data1, data2, out_ready,
    input  in_ready, out_valid, d_out, zero_flag,
    input  exp_overflow, exp_illegal, div_zero, hi, lo
  );

  modport slave (
    input  in_valid, alu_op, data1, data2, out_ready,
    output in_ready, out_valid, d_out, zero_flag,
    output exp_overflow, exp_illegal, div_zero, hi, lo
  );
endinterface

// File: rtl/alu_md_iter.sv
// alu_md_iter: iterative shift-add multiplier / restoring divider on magnitudes.
// Divider step exists only when ALU_MD_DIV_EN is defined.
module alu_md_iter
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic             div_r;
  logic             neg_q;
  logic             neg_r;
  logic             div_sel;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] nxt_acc;
  logic [WIDTH-1:0] nxt_q;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign mag_a = a_neg ? (~a + 1'b1) : a;
  assign mag_b = b_neg ? (~b + 1'b1) : b;
  assign done  = run && (cnt == CNT_W'(WIDTH));

`ifdef ALU_MD_DIV_EN
  logic [WIDTH:0]   shifted;
  logic             ge;
  assign div_sel = div_r;
  assign shifted = {acc, q[WIDTH-1]};
  assign ge      = shifted >= {1'b0, dvs};
`else
  logic unused_div;
  assign div_sel    = 1'b0;
  assign unused_div = div_r | neg_r;
`endif

  // one iteration of whichever algorithm is running
  always_comb begin
    nxt_acc = acc;
    nxt_q   = q;
    sum     = '0;
`ifdef ALU_MD_DIV_EN
    if (div_r) begin
      if (ge) begin
        nxt_acc = shifted[WIDTH-1:0] - dvs;
        nxt_q   = {q[WIDTH-2:0], 1'b1};
      end else begin
        nxt_acc = shifted[WIDTH-1:0];
        nxt_q   = {q[WIDTH-2:0], 1'b0};
      end
    end else
`endif
    begin
      sum     = q[0] ? ({1'b0, acc} + {1'b0, dvs})
                     : {1'b0, acc};
      nxt_acc = sum[WIDTH:1];
      nxt_q   = {sum[0], q[WIDTH-1:1]};
    end
  end

  // load on start, then step until WIDTH iterations are counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      q     <= '0;
      dvs   <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      div_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      acc   <= '0;
      q     <= mag_a;
      dvs   <= mag_b;
      cnt   <= '0;
      run   <= 1'b1;
      div_r <= is_div;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end else if (run && !done) begin
      acc <= nxt_acc;
      q   <= nxt_q;
      cnt <= cnt + 1'b1;
    end
  end

  // sign fix-up applied to the finished magnitudes
  always_comb begin
    prod   = {acc, q};
    prod_s = neg_q ? (~prod + 1'b1) : prod;
    quo_s  = neg_q ? (~q + 1'b1) : q;
    rem_s  = neg_r ? (~acc + 1'b1) : acc;
    res_hi = div_sel ? rem_s : prod_s[2*WIDTH-1:WIDTH];
    res_lo = div_sel ? quo_s : prod_s[WIDTH-1:0];
  end

endmodule

// File: rtl/alu_md.sv
// alu_md: handshaked EX-stage ALU with iterative mul/div and HI/LO.
// ALU_MD_DIV_EN: when undefined DIV/DIVU retire as illegal ops.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  alu_md_if.slave  bus
);
  state_t           state;
  state_t           nxt;
  logic             in_ready;
  logic             accept;
  logic             md_op;
  logic             md_go;
  logic             it_done;
  logic [WIDTH-1:0] it_hi;
  logic [WIDTH-1:0] it_lo;

  logic [WIDTH-1:0] d_out_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] a_keep;
  logic             zf_q;
  logic             ov_q;
  logic             ill_q;
  logic             dz_q;

  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [3:0]       op;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ov;
  logic             sc_ill;

  assign d1 = bus.data1;
  assign d2 = bus.data2;
  assign op = bus.alu_op;

  assign md_op  = is_md(op) && (DIV_EN || !op[1]);
  assign accept = bus.in_valid & in_ready;
  assign md_go  = accept & md_op;

  assign add_s = {d1[WIDTH-1], d1} + {d2[WIDTH-1], d2};
  assign sub_s = {d1[WIDTH-1], d1} - {d2[WIDTH-1], d2};

  alu_md_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (md_go),
    .is_div    (op[1]),
    .is_signed (~op[0]),
    .a         (d1),
    .b         (d2),
    .done      (it_done),
    .res_hi    (it_hi),
    .res_lo    (it_lo)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next state and issue-side ready
  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) nxt = md_op ? BUSY : DONE;
      end
      BUSY: begin
        if (it_done) nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          in_ready = 1'b1;
          if (bus.in_valid) nxt = md_op ? BUSY : DONE;
          else              nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // single-cycle result and flags
  always_comb begin
    sc_res = '0;
    sc_ov  = 1'b0;
    sc_ill = 1'b0;
    unique case (op)
      OP_ADD: begin
        sc_res = add_s[WIDTH-1:0];
        sc_ov  = add_s[WIDTH] ^ add_s[WIDTH-1];
      end
      OP_SUB: begin
        sc_res = sub_s[WIDTH-1:0];
        sc_ov  = sub_s[WIDTH] ^ sub_s[WIDTH-1];
      end
      OP_OR:   sc_res = d1 | d2;
      OP_SLT:  sc_res = WIDTH'($signed(d1) < $signed(d2));
      OP_SLTU: sc_res = WIDTH'(d1 < d2);
      OP_MULT, OP_MULTU: sc_res = '0;
      OP_DIV, OP_DIVU:   sc_ill = !DIV_EN;
      OP_MFHI: sc_res = hi_q;
      OP_MFLO: sc_res = lo_q;
      OP_MTHI, OP_MTLO: sc_res = d1;
      default: sc_ill = 1'b1;
    endcase
  end

  // capture at accept; md results land on DONE entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_keep  <= '0;
      zf_q    <= 1'b0;
      ov_q    <= 1'b0;
      ill_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else if (accept) begin
      zf_q   <= d1 == d2;
      ov_q   <= sc_ov & ~md_op;
      ill_q  <= sc_ill & ~md_op;
      dz_q   <= md_op & op[1] & (d2 == '0);
      a_keep <= d1;
      if (!md_op)        d_out_q <= sc_res;
      if (op == OP_MTHI) hi_q    <= d1;
      if (op == OP_MTLO) lo_q    <= d1;
    end else if (state == BUSY && it_done) begin
      if (dz_q) begin
        hi_q    <= a_keep;
        lo_q    <= '1;
        d_out_q <= '1;
      end else begin
        hi_q    <= it_hi;
        lo_q    <= it_lo;
        d_out_q <= it_lo;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = state == DONE;
  assign bus.d_out        = d_out_q;
  assign bus.zero_flag    = zf_q;
  assign bus.exp_overflow = ov_q;
  assign bus.exp_illegal  = ill_q;
  assign bus.div_zero     = dz_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed vectors for alu_md with hand-computed expectations.
// Divider vectors follow ALU_MD_DIV_EN the same way the design does.
module tb_alu_md;
  import alu_md_pkg::*;

  logic clk;
  logic rst;
  int   vec;
  int   errs;

  alu_md_if #(.WIDTH(32)) bus ();

  alu_md #(
    .WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // present one op for exactly one accept edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.data1    = a;
    bus.data2    = b;
    step();
    bus.in_valid = 1'b0;
  endtask

  // cycles from accept edge to out_valid, bounded
  task automatic wait_done(output int cyc, output bit rdy_seen);
    cyc      = 0;
    rdy_seen = 1'b0;
    while (cyc < 40) begin
      step();
      cyc++;
      if (bus.out_valid) break;
      if (bus.in_ready) rdy_seen = 1'b1;
    end
  endtask

  int cyc;
  bit rdy_seen;
  bit bad;

  initial begin
    vec           = 0;
    errs          = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alu_op    = OP_ADD;
    bus.data1     = '0;
    bus.data2     = '0;
    bus.out_ready = 1'b1;
    step();
    step();

    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_d_out", bus.d_out, 32'h0);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_flags", {28'h0, bus.zero_flag, bus.exp_overflow,
        bus.exp_illegal, bus.div_zero}, 32'h0);
    rst = 1'b0;
    step();

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_d_out", bus.d_out, 32'h8000_0000);
    chk("add_ovf", 32'(bus.exp_overflow), 32'd1);
    chk("add_zf", 32'(bus.zero_flag), 32'd0);

    issue(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("slt_d_out", bus.d_out, 32'd1);
    chk("slt_ovf", 32'(bus.exp_overflow), 32'd0);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("sltu_d_out", bus.d_out, 32'd0);

    issue(OP_SUB, 32'h8000_0000, 32'h0000_0001);
    chk("sub_d_out", bus.d_out, 32'h7FFF_FFFF);
    chk("sub_ovf", 32'(bus.exp_overflow), 32'd1);
    issue(OP_SUB, 32'h0000_1234, 32'h0000_1234);
    chk("sub_eq_d_out", bus.d_out, 32'h0);
    chk("sub_eq_zf", 32'(bus.zero_flag), 32'd1);
    issue(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F);
    chk("or_d_out", bus.d_out, 32'hF0F0_0F0F);

    issue(4'd6, 32'h1111_1111, 32'h2222_2222);
    chk("rsv_valid", 32'(bus.out_valid), 32'd1);
    chk("rsv_d_out", bus.d_out, 32'h0);
    chk("rsv_ill", 32'(bus.exp_illegal), 32'd1);

    issue(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.alu_op    = OP_ADD;
    bus.data1     = 32'd1;
    bus.data2     = 32'd1;
    wait_done(cyc, rdy_seen);
    chk("mult_latency", 32'(cyc), 32'd33);
    chk("mult_busy_rdy", 32'(rdy_seen), 32'd0);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
    chk("mult_d_out", bus.d_out, 32'hFFFF_FFFA);
    chk("mult_hold_rdy", 32'(bus.in_ready), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("mult_to_idle", 32'(bus.out_valid), 32'd0);

`ifdef ALU_MD_DIV_EN
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(cyc, rdy_seen);
    chk("div_latency", 32'(cyc), 32'd33);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);
    chk("div_dz", 32'(bus.div_zero), 32'd0);
    issue(OP_DIVU, 32'h0000_0007, 32'h0000_0000);
    wait_done(cyc, rdy_seen);
    chk("divz_latency", 32'(cyc), 32'd33);
    chk("divz_lo", bus.lo, 32'hFFFF_FFFF);
    chk("divz_hi", bus.hi, 32'h0000_0007);
    chk("divz_dz", 32'(bus.div_zero), 32'd1);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, rdy_seen);
    chk("divmin_lo", bus.lo, 32'h8000_0000);
    chk("divmin_hi", bus.hi, 32'h0);
    chk("divmin_flags", {28'h0, bus.zero_flag, bus.exp_overflow,
        bus.exp_illegal, bus.div_zero}, 32'h0);
`else
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    chk("div_off_valid", 32'(bus.out_valid), 32'd1);
    chk("div_off_d_out", bus.d_out, 32'h0);
    chk("div_off_ill", 32'(bus.exp_illegal), 32'd1);
    chk("div_off_hi", bus.hi, 32'hFFFF_FFFF);
    chk("div_off_lo", bus.lo, 32'hFFFF_FFFA);
    issue(OP_DIVU, 32'h0000_0007, 32'h0000_0000);
    chk("divu_off_ill", 32'(bus.exp_illegal), 32'd1);
    chk("divu_off_dz", 32'(bus.div_zero), 32'd0);
`endif
    step();

    issue(OP_MULTU, 32'd3, 32'd5);
    bus.out_ready = 1'b0;
    wait_done(cyc, rdy_seen);
    chk("multu_d_out", bus.d_out, 32'd15);
    chk("multu_hi", bus.hi, 32'd0);
    bus.in_valid = 1'b1;
    bus.alu_op   = OP_ADD;
    bus.data1    = 32'd2;
    bus.data2    = 32'd3;
    bad          = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.d_out !== 32'd15 || bus.out_valid !== 1'b1) bad = 1'b1;
    end
    chk("hold_stable", 32'(bad), 32'd0);
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("b2b_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_d_out", bus.d_out, 32'd5);
    step();

    issue(OP_MULT, 32'd3, 32'd5);
    repeat (10) step();
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_hi", bus.hi, 32'h0);
    chk("abort_lo", bus.lo, 32'h0);
    chk("abort_rdy", 32'(bus.in_ready), 32'd1);
    step();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid !== 1'b0) bad = 1'b1;
    end
    chk("abort_no_valid", 32'(bad), 32'd0);

    issue(OP_MTHI, 32'h0000_1234, 32'h0);
    chk("mthi_d_out", bus.d_out, 32'h0000_1234);
    chk("mthi_hi", bus.hi, 32'h0000_1234);
    issue(OP_MFHI, 32'h0, 32'h0);
    chk("mfhi_d_out", bus.d_out, 32'h0000_1234);
    issue(OP_MTLO, 32'hCAFE_0001, 32'h0);
    chk("mtlo_lo", bus.lo, 32'hCAFE_0001);
    chk("mtlo_hi_kept", bus.hi, 32'h0000_1234);
    issue(OP_MFLO, 32'h0, 32'h0);
    chk("mflo_d_out", bus.d_out, 32'hCAFE_0001);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
